// File: rtl/uart_pkg.sv
// Shared types and constants for the byte-serial UART transmitter.
//   uart_state_e : transmitter FSM states
//   UART_DATA_W  : payload width
//   baud_div()   : clock cycles per bit for a given clock/line rate
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } uart_state_e;

    // Integer cycles per bit; truncating division is intended.
    function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter for the UART transmitter.
//   clk, reset_n : clock, async active-low reset
//   clr          : hold the count at zero
//   count        : current position inside the bit period
//   tick         : high in the last cycle of a bit period
module uart_baud_cnt #(
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        clr,
    output logic [$clog2(BAUD_DIV)-1:0] count,
    output logic                        tick
);

    localparam int unsigned CNT_W = $clog2(BAUD_DIV);

    assign tick = (count == CNT_W'(BAUD_DIV - 1));

    // Free-running modulo-BAUD_DIV counter, restarted by clr.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr || tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_byte.sv
// 8N1 LSB-first UART transmitter fed by a FIFO read stream.
//   clk, reset_n : clock, async active-low reset
//   tx_en        : send request, honoured only while idle
//   tx_data      : byte, captured LOAD_DLY cycles after the request
//   tx_ready     : idle and not currently being requested (to data_vld)
//   txd          : serial line, idle high, registered
//   tx_busy      : frame in progress
//   tx_done      : pulse in the last stop-bit cycle
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 115200,
    parameter int unsigned BAUD_DIV = baud_div(CLK_FREQ, BAUD),
    parameter int unsigned LOAD_DLY = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   tx_en,
    input  logic [UART_DATA_W-1:0] tx_data,
    output logic                   tx_ready,
    output logic                   txd,
    output logic                   tx_busy,
    output logic                   tx_done
);

    localparam int unsigned CNT_W = $clog2(BAUD_DIV);
    localparam int unsigned LC_W  = $clog2(LOAD_DLY + 1);

    uart_state_e            state, state_nxt;
    logic [UART_DATA_W-1:0] shreg, shreg_nxt;
    logic [2:0]             bit_idx, bit_idx_nxt;
    logic [LC_W-1:0]        load_cnt, load_cnt_nxt;
    logic                   txd_nxt, tx_busy_nxt, tx_done_nxt;
    logic                   baud_clr;
    logic                   baud_tick;
    logic [CNT_W-1:0]       baud_count;

    uart_baud_cnt #(.BAUD_DIV(BAUD_DIV)) u_baud (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (baud_clr),
        .count   (baud_count),
        .tick    (baud_tick)
    );

    // Drops in the request cycle so a registered requester pops exactly once.
    assign tx_ready = (state == IDLE) & ~tx_en;

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_idx  <= '0;
            load_cnt <= '0;
            txd      <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_nxt;
            shreg    <= shreg_nxt;
            bit_idx  <= bit_idx_nxt;
            load_cnt <= load_cnt_nxt;
            txd      <= txd_nxt;
            tx_busy  <= tx_busy_nxt;
            tx_done  <= tx_done_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt    = state;
        shreg_nxt    = shreg;
        bit_idx_nxt  = bit_idx;
        load_cnt_nxt = load_cnt;
        baud_clr     = 1'b0;
        txd_nxt      = 1'b1;

        case (state)
            IDLE: begin
                baud_clr = 1'b1;
                if (tx_en) begin
                    state_nxt    = LOAD;
                    load_cnt_nxt = '0;
                end
            end
            LOAD: begin
                // Baud counter held at zero so START begins a full period.
                baud_clr = 1'b1;
                if (load_cnt == LC_W'(LOAD_DLY - 1)) begin
                    shreg_nxt = tx_data;
                    state_nxt = START;
                end else begin
                    load_cnt_nxt = load_cnt + LC_W'(1);
                end
            end
            START: begin
                if (baud_tick) begin
                    state_nxt   = DATA;
                    bit_idx_nxt = '0;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    shreg_nxt   = shreg >> 1;
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Line level follows the state being entered, keeping txd a clean flop.
        case (state_nxt)
            START:   txd_nxt = 1'b0;
            DATA:    txd_nxt = shreg_nxt[0];
            default: txd_nxt = 1'b1;
        endcase

        tx_busy_nxt = (state_nxt != IDLE);
        // Registered one cycle early so the pulse lands on the last stop cycle.
        tx_done_nxt = (state == STOP) && (baud_count == CNT_W'(BAUD_DIV - 2));
    end

endmodule

// File: tb/tb_uart_tx_byte.sv
// Self-checking bench for uart_tx_byte with a registered FIFO/controller model.
module tb_uart_tx_byte;

    localparam int BD     = 10;
    localparam int M_NORM = 0;
    localparam int M_HOLD = 1;
    localparam int M_RST  = 2;
    localparam int M_OVR  = 3;

    logic       clk;
    logic       reset_n;
    logic       tx_en;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       txd;
    logic       tx_busy;
    logic       tx_done;

    logic       ctl_en_r;
    logic       hold_en     = 1'b0;
    logic       data_ovr_en = 1'b0;
    logic [7:0] fifo_dout   = 8'h00;
    logic [7:0] mem [32];
    int         wr_ptr      = 0;
    int         rd_ptr      = 0;
    int         pops        = 0;
    int         cyc         = 0;
    int         last_done   = 0;
    int         checks      = 0;
    int         failures    = 0;

    assign tx_en   = ctl_en_r | hold_en;
    assign tx_data = data_ovr_en ? 8'h55 : fifo_dout;

    uart_tx_byte #(
        .CLK_FREQ (1000),
        .BAUD     (100),
        .LOAD_DLY (1)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .tx_en    (tx_en),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .txd      (txd),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered requester: asks while data is pending and the transmitter is ready.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) ctl_en_r <= 1'b0;
        else          ctl_en_r <= (wr_ptr != rd_ptr) && tx_ready && !ctl_en_r;
    end

    // FIFO with one cycle of read latency.
    always @(posedge clk) begin
        if (ctl_en_r) begin
            fifo_dout <= mem[rd_ptr % 32];
            rd_ptr    <= rd_ptr + 1;
            pops      <= pops + 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Expected line level k cycles after the first start-bit cycle.
    function automatic logic exp_txd(input logic [7:0] b, input int k);
        int bitn;
        bitn = k / BD;
        if (bitn == 0) return 1'b0;
        if (bitn >= 9) return 1'b1;
        return b[bitn-1];
    endfunction

    task automatic push(input logic [7:0] b);
        mem[wr_ptr % 32] = b;
        wr_ptr++;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_txd"},   32'(txd),      32'(1));
        chk({tag, "_busy"},  32'(tx_busy),  32'(0));
        chk({tag, "_done"},  32'(tx_done),  32'(0));
        chk({tag, "_ready"}, 32'(tx_ready), 32'(1));
    endtask

    // Waits for the next frame and checks it cycle by cycle against byte b.
    task automatic check_frame(input logic [7:0] b, input int mode, input bit b2b);
        int req;
        int start;
        bit found;
        req   = -100;
        found = 1'b0;
        for (int t = 0; t < 60; t++) begin
            if (tx_en === 1'b1) req = cyc;
            if (txd === 1'b0) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("start_found", 32'(found), 32'(1));
        if (!found) return;
        start = cyc;
        chk("start_latency", 32'(start - req), 32'(2));
        if (b2b) chk("frame_gap", 32'(start - last_done), 32'(4));
        for (int k = 0; k < 10 * BD; k++) begin
            chk("txd",     32'(txd),     32'(exp_txd(b, k)));
            chk("busy",    32'(tx_busy), 32'(1));
            chk("done",    32'(tx_done), 32'(k == 10 * BD - 1));
            if (mode == M_OVR && k == 0) data_ovr_en = 1'b1;
            if (mode == M_HOLD && k == 2 * BD - 1) hold_en = 1'b1;
            if (mode == M_HOLD && k == 4 * BD - 1) hold_en = 1'b0;
            if (mode == M_RST && k == 5 * BD + 3) begin
                #1 reset_n = 1'b0;
                #1;
                chk_idle("rst_async");
                @(negedge clk);
                @(negedge clk);
                reset_n = 1'b1;
                repeat (3) @(negedge clk);
                chk_idle("rst_release");
                return;
            end
            @(negedge clk);
        end
        last_done   = start + 10 * BD - 1;
        data_ovr_en = 1'b0;
        hold_en     = 1'b0;
        chk_idle("post_frame");
    endtask

    initial begin
        logic [7:0] x;
        logic [7:0] y;
        int         p0;

        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle("in_reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_idle("reset_release");

        // Single frame.
        p0 = pops;
        push(8'hA5);
        check_frame(8'hA5, M_NORM, 1'b0);
        chk("pops_single", 32'(pops - p0), 32'(1));

        // Streamed bytes, back to back.
        p0 = pops;
        push(8'h00);
        push(8'hFF);
        push(8'h3C);
        check_frame(8'h00, M_NORM, 1'b0);
        check_frame(8'hFF, M_NORM, 1'b1);
        check_frame(8'h3C, M_NORM, 1'b1);
        chk("pops_stream", 32'(pops - p0), 32'(3));

        // Request held high during DATA is ignored.
        p0 = pops;
        x  = 8'($urandom);
        y  = 8'($urandom);
        push(x);
        push(y);
        check_frame(x, M_HOLD, 1'b0);
        check_frame(y, M_NORM, 1'b1);
        chk("pops_hold", 32'(pops - p0), 32'(2));

        // Reset while data bit 4 (a zero) is on the line.
        x = 8'($urandom) & 8'hEF;
        push(x);
        check_frame(x, M_RST, 1'b0);
        push(8'h81);
        check_frame(8'h81, M_NORM, 1'b0);

        // tx_data changes after the capture edge.
        push(8'hC3);
        check_frame(8'hC3, M_OVR, 1'b0);

        // Random bytes with random idle gaps.
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            x  = 8'($urandom);
            p0 = pops;
            push(x);
            check_frame(x, M_NORM, 1'b0);
            chk("pops_rand", 32'(pops - p0), 32'(1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
